// File: rtl/conv_window_buf_pkg.sv
// Shared definitions for the conv window buffer slice.
// Default sample width, ceil-log2 and window element indexing.
package conv_window_buf_pkg;

   localparam int DEF_DATA_BITS = 12;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   function automatic int elem_idx(input int r, input int c, input int k);
      return r * k + c;
   endfunction

endpackage

// File: rtl/conv_line_fifo.sv
// Fixed-length delay line for one image row.
// Output is the sample written DEPTH accepted beats ago.
module conv_line_fifo
   import conv_window_buf_pkg::*;
#(
   parameter int DEPTH = 12,
   parameter int W     = 12
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   localparam int AW = clog2(DEPTH);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] ptr;

   // Circular pointer, one slot per accepted beat
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (en) begin
         ptr <= (ptr == LAST) ? '0 : ptr + AW'(1);
      end
   end

   // Storage is deliberately left unreset
   always_ff @(posedge clk) begin
      if (en) mem[ptr] <= din;
   end

   assign dout = mem[ptr];

endmodule

// File: rtl/conv_window_buf.sv
// KxK sliding window generator over a raster pixel stream.
// K-1 cascaded line buffers feed a KxK shift-register window.
module conv_window_buf
   import conv_window_buf_pkg::*;
#(
   parameter int WIDTH     = 12,
   parameter int HEIGHT    = 12,
   parameter int DATA_BITS = DEF_DATA_BITS,
   parameter int K         = 5,
   parameter int CH        = 1,
   parameter int STRIDE    = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          valid_in,
   input  logic [CH*DATA_BITS-1:0]       data_in,
   output logic [K*K*CH*DATA_BITS-1:0]   window_out,
   output logic                          valid_out,
   output logic [clog2(HEIGHT)-1:0]      out_row,
   output logic [clog2(WIDTH)-1:0]       out_col,
   output logic                          frame_done
);

   localparam int RW = clog2(HEIGHT);
   localparam int CW = clog2(WIDTH);
   localparam int PW = CH * DATA_BITS;
   localparam int OC_MAX = (WIDTH - K) / STRIDE;
   localparam int OR_MAX = (HEIGHT - K) / STRIDE;
   localparam logic PH_LAST = (STRIDE == 2);

   logic [CW-1:0] col, c_oc;
   logic [RW-1:0] row, r_oc;
   logic          c_ph, r_ph;
   logic          col_last, row_last, col_in, row_in;
   logic          hit, last_pos;
   logic [PW-1:0] lb_out  [K-1];
   logic [PW-1:0] new_col [K];
   logic [PW-1:0] win     [K][K];

   for (genvar i = 0; i < K - 1; i++) begin : g_lb
      if (i == K - 2) begin : g_head
         conv_line_fifo #(.DEPTH(WIDTH), .W(PW)) u_lb (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (valid_in),
            .din  (data_in),
            .dout (lb_out[i])
         );
      end else begin : g_tail
         conv_line_fifo #(.DEPTH(WIDTH), .W(PW)) u_lb (
            .clk  (clk),
            .rst_n(rst_n),
            .en   (valid_in),
            .din  (lb_out[i+1]),
            .dout (lb_out[i])
         );
      end
   end

   assign col_last = (col == CW'(WIDTH - 1));
   assign row_last = (row == RW'(HEIGHT - 1));
   assign col_in   = (col >= CW'(K - 1));
   assign row_in   = (row >= RW'(K - 1));
   assign hit      = valid_in && col_in && row_in && !c_ph && !r_ph;
   assign last_pos = (c_oc == CW'(OC_MAX)) && (r_oc == RW'(OR_MAX));

   // Incoming column: oldest row at the top, live pixel at the bottom
   always_comb begin
      for (int r = 0; r < K - 1; r++) new_col[r] = lb_out[r];
      new_col[K-1] = data_in;
   end

   // Raster position plus stride-phase and output-index counters
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         col  <= '0;
         row  <= '0;
         c_ph <= 1'b0;
         r_ph <= 1'b0;
         c_oc <= '0;
         r_oc <= '0;
      end else if (valid_in) begin
         if (col_last) begin
            col  <= '0;
            c_ph <= 1'b0;
            c_oc <= '0;
            if (row_last) begin
               row  <= '0;
               r_ph <= 1'b0;
               r_oc <= '0;
            end else begin
               row <= row + RW'(1);
               if (row_in) begin
                  if (r_ph == PH_LAST) begin
                     r_ph <= 1'b0;
                     r_oc <= r_oc + RW'(1);
                  end else begin
                     r_ph <= 1'b1;
                  end
               end
            end
         end else begin
            col <= col + CW'(1);
            if (col_in) begin
               if (c_ph == PH_LAST) begin
                  c_ph <= 1'b0;
                  c_oc <= c_oc + CW'(1);
               end else begin
                  c_ph <= 1'b1;
               end
            end
         end
      end
   end

   // Window pulse, frame end and output position
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_out  <= 1'b0;
         frame_done <= 1'b0;
         out_row    <= '0;
         out_col    <= '0;
      end else begin
         valid_out  <= hit;
         frame_done <= hit && last_pos;
         if (hit) begin
            out_row <= r_oc;
            out_col <= c_oc;
         end
      end
   end

   // Shift window columns left and load the new column on the right
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) win[r][c] <= '0;
         end
      end else if (valid_in) begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) win[r][c] <= win[r][c+1];
            win[r][K-1] <= new_col[r];
         end
      end
   end

   // Flatten window registers into the output bus
   always_comb begin
      window_out = '0;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K; c++) begin
            window_out[elem_idx(r, c, K)*PW +: PW] = win[r][c];
         end
      end
   end

endmodule
